// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types, width helpers and defaults for the sprite compositor
package sprite_pkg;

  localparam int DEF_NUM_SPR = 4;
  localparam int DEF_SPR_W   = 60;
  localparam int DEF_SPR_H   = 60;
  localparam int DEF_NUM_FRM = 6;
  localparam int DEF_ADDR_W  = 15;
  localparam int CFG_COORD_W = 10;
  localparam int CFG_COLOR_W = 12;

  // Width of an index into n items; never narrower than one bit
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int CFG_FRM_W = clog2w(DEF_NUM_FRM);

  // One channel's programmable configuration as held in the shadow register
  typedef struct packed {
    logic signed [CFG_COORD_W-1:0] x;
    logic signed [CFG_COORD_W-1:0] y;
    logic [CFG_FRM_W-1:0]          frm;
    logic [CFG_COLOR_W-1:0]        color;
    logic                          vis;
  } spr_cfg_t;

endpackage

// File: rtl/sprite_channel.sv
// rtl/sprite_channel.sv - one sprite channel: shadow/live config, box test, ROM address, opacity
module sprite_channel
  import sprite_pkg::*;
#(
  parameter int SPR_W   = DEF_SPR_W,
  parameter int SPR_H   = DEF_SPR_H,
  parameter int NUM_FRM = DEF_NUM_FRM,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int COORD_W = CFG_COORD_W,
  parameter int COLOR_W = CFG_COLOR_W,
  parameter int FRM_W   = clog2w(NUM_FRM)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  input  logic               frame_start,
  input  logic               wr_sel,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [FRM_W-1:0]   wr_frm,
  input  logic [COLOR_W-1:0] wr_color,
  input  logic               wr_vis,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               rom_bit,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic [COLOR_W-1:0] color,
  output logic               opaque
);

  localparam int FRM_PIX = SPR_W * SPR_H;

  spr_cfg_t                  shadow;
  logic [FRM_W-1:0]          frm_clamped;
  logic signed [COORD_W-1:0] sx;
  logic signed [COORD_W-1:0] sy;
  logic                      vis;
  logic [ADDR_W-1:0]         frm_base;
  logic signed [COORD_W:0]   dx;
  logic signed [COORD_W:0]   dy;
  logic                      hit;
  logic [ADDR_W-1:0]         addr_next;
  logic                      in_box;

  // Out-of-range frame numbers select the last frame so the address stays inside the ROM
  always_comb begin
    frm_clamped = wr_frm;
    if (32'(wr_frm) >= NUM_FRM) frm_clamped = FRM_W'(NUM_FRM - 1);
  end

  // Shadow register: writable on any clk, invisible to the pixel path until the frame boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
    end else if (wr_sel) begin
      shadow.x     <= wr_x;
      shadow.y     <= wr_y;
      shadow.frm   <= frm_clamped;
      shadow.color <= wr_color;
      shadow.vis   <= wr_vis;
    end
  end

  // Live register: copied once per frame; frame base multiply happens here, not per pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sx       <= '0;
      sy       <= '0;
      vis      <= 1'b0;
      color    <= '0;
      frm_base <= '0;
    end else if (pix_en && frame_start) begin
      sx       <= shadow.x;
      sy       <= shadow.y;
      vis      <= shadow.vis;
      color    <= shadow.color;
      frm_base <= ADDR_W'(shadow.frm) * ADDR_W'(FRM_PIX);
    end
  end

  // Box test in one extra bit of signed range so off-screen positions never wrap into the box
  always_comb begin
    dx        = $signed({1'b0, x}) - $signed({sx[COORD_W-1], sx});
    dy        = $signed({1'b0, y}) - $signed({sy[COORD_W-1], sy});
    hit       = vis && (dx >= 0) && (int'(dx) < SPR_W) && (dy >= 0) && (int'(dy) < SPR_H);
    addr_next = frm_base + ADDR_W'($unsigned(dy)) * ADDR_W'(SPR_W) + ADDR_W'($unsigned(dx));
  end

  // Stage 1: register box hit and ROM address (address parked at 0 outside the box)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_box   <= 1'b0;
      rom_addr <= '0;
    end else if (pix_en) begin
      in_box   <= hit;
      rom_addr <= hit ? addr_next : '0;
    end
  end

  // Stage 2 input: pixel is ink only when inside the box and the ROM bit is set
  always_comb opaque = in_box & rom_bit;

endmodule

// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - N-channel 1-bpp sprite overlay with priority mux and collision flags
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter  int NUM_SPR = DEF_NUM_SPR,
  parameter  int SPR_W   = DEF_SPR_W,
  parameter  int SPR_H   = DEF_SPR_H,
  parameter  int NUM_FRM = DEF_NUM_FRM,
  parameter  int ADDR_W  = DEF_ADDR_W,
  parameter  int COORD_W = CFG_COORD_W,
  parameter  int COLOR_W = CFG_COLOR_W,
  localparam int IDX_W   = clog2w(NUM_SPR),
  localparam int FRM_W   = clog2w(NUM_FRM)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pix_en,
  input  logic                        frame_start,
  input  logic [COORD_W-1:0]          x,
  input  logic [COORD_W-1:0]          y,
  input  logic                        active,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic [COLOR_W-1:0]          bg_color,
  input  logic                        wr_en,
  input  logic [IDX_W-1:0]            wr_idx,
  input  logic [COORD_W-1:0]          wr_x,
  input  logic [COORD_W-1:0]          wr_y,
  input  logic [FRM_W-1:0]            wr_frm,
  input  logic [COLOR_W-1:0]          wr_color,
  input  logic                        wr_vis,
  output logic [NUM_SPR*ADDR_W-1:0]   rom_addr,
  input  logic [NUM_SPR-1:0]          rom_data,
  output logic [COLOR_W-1:0]          rgb_out,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic [NUM_SPR*NUM_SPR-1:0]  collide,
  output logic                        collide_any
);

  logic [NUM_SPR-1:0]         opaque;
  logic [COLOR_W-1:0]         spr_color [NUM_SPR];
  logic                       vld1;
  logic                       act1;
  logic                       hs1;
  logic                       vs1;
  logic [COLOR_W-1:0]         bg1;
  logic [COLOR_W-1:0]         pix_color;
  logic [NUM_SPR*NUM_SPR-1:0] pair_hit;
  logic [NUM_SPR*NUM_SPR-1:0] acc;

  for (genvar i = 0; i < NUM_SPR; i++) begin : g_chan
    logic wr_sel;
    // Indices at or above NUM_SPR match no channel, so such writes are dropped
    always_comb wr_sel = wr_en && (32'(wr_idx) == i);

    sprite_channel #(
      .SPR_W   (SPR_W),
      .SPR_H   (SPR_H),
      .NUM_FRM (NUM_FRM),
      .ADDR_W  (ADDR_W),
      .COORD_W (COORD_W),
      .COLOR_W (COLOR_W),
      .FRM_W   (FRM_W)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .pix_en      (pix_en),
      .frame_start (frame_start),
      .wr_sel      (wr_sel),
      .wr_x        (wr_x),
      .wr_y        (wr_y),
      .wr_frm      (wr_frm),
      .wr_color    (wr_color),
      .wr_vis      (wr_vis),
      .x           (x),
      .y           (y),
      .rom_bit     (rom_data[i]),
      .rom_addr    (rom_addr[i*ADDR_W +: ADDR_W]),
      .color       (spr_color[i]),
      .opaque      (opaque[i])
    );
  end

  // Stage 1: carry timing and background alongside the channel address stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld1 <= 1'b0;
      act1 <= 1'b0;
      hs1  <= 1'b1;
      vs1  <= 1'b1;
      bg1  <= '0;
    end else if (pix_en) begin
      vld1 <= 1'b1;
      act1 <= active;
      hs1  <= hsync_in;
      vs1  <= vsync_in;
      bg1  <= bg_color;
    end
  end

  // Fixed priority: the lowest-numbered opaque channel wins, else background
  always_comb begin
    pix_color = bg1;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (opaque[i]) pix_color = spr_color[i];
    end
  end

  // Stage 2: composited colour, blanked outside the visible region
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_out   <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else if (pix_en) begin
      rgb_out   <= (vld1 && act1) ? pix_color : '0;
      hsync_out <= hs1;
      vsync_out <= vs1;
    end
  end

  // Symmetric pairwise overlap of the pixel currently being resolved; diagonal stays 0
  always_comb begin
    pair_hit = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      for (int j = 0; j < NUM_SPR; j++) begin
        if (i != j) pair_hit[i*NUM_SPR + j] = opaque[i] & opaque[j];
      end
    end
  end

  // Sticky per-frame accumulator; published (including the boundary pixel) at frame_start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      collide <= '0;
    end else if (pix_en) begin
      if (frame_start) begin
        collide <= acc | pair_hit;
        acc     <= '0;
      end else begin
        acc <= acc | pair_hit;
      end
    end
  end

  always_comb collide_any = |collide;

endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - directed self-checking bench for sprite_compositor
module tb_sprite_compositor;
  localparam int NS = 4;
  localparam int AW = 15;
  localparam logic [11:0] BG = 12'h123;

  logic          clk = 1'b0;
  logic          reset;
  logic          pix_en;
  logic          frame_start;
  logic [9:0]    x;
  logic [9:0]    y;
  logic          active;
  logic          hsync_in;
  logic          vsync_in;
  logic [11:0]   bg_color;
  logic          wr_en;
  logic [1:0]    wr_idx;
  logic [9:0]    wr_x;
  logic [9:0]    wr_y;
  logic [2:0]    wr_frm;
  logic [11:0]   wr_color;
  logic          wr_vis;
  logic [NS*AW-1:0] rom_addr;
  logic [NS-1:0] rom_data;
  logic [11:0]   rgb_out;
  logic          hsync_out;
  logic          vsync_out;
  logic [NS*NS-1:0] collide;
  logic          collide_any;

  int n_checks = 0;
  int n_pass   = 0;

  sprite_compositor dut (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .frame_start (frame_start),
    .x           (x),
    .y           (y),
    .active      (active),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .bg_color    (bg_color),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_frm      (wr_frm),
    .wr_color    (wr_color),
    .wr_vis      (wr_vis),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .rgb_out     (rgb_out),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .collide     (collide),
    .collide_any (collide_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [AW-1:0] addr(input int ch);
    return rom_addr[ch*AW +: AW];
  endfunction

  task automatic set_wr(input int idx, input int wx, input int wy, input int frm,
                        input logic [11:0] col, input logic vis);
    wr_idx   = 2'(idx);
    wr_x     = 10'(wx);
    wr_y     = 10'(wy);
    wr_frm   = 3'(frm);
    wr_color = col;
    wr_vis   = vis;
  endtask

  task automatic wr(input int idx, input int wx, input int wy, input int frm,
                    input logic [11:0] col, input logic vis);
    @(negedge clk);
    set_wr(idx, wx, wy, frm, col, vis);
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // One pixel strobe; returns on a negedge well after the strobe edge
  task automatic pix(input int px, input int py, input logic act, input logic fs,
                     input logic with_wr = 1'b0);
    @(negedge clk);
    x           = 10'(px);
    y           = 10'(py);
    active      = act;
    frame_start = fs;
    wr_en       = with_wr;
    pix_en      = 1'b1;
    @(negedge clk);
    pix_en      = 1'b0;
    frame_start = 1'b0;
    wr_en       = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; pix_en = 1'b0; frame_start = 1'b0; x = '0; y = '0; active = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; bg_color = BG; wr_en = 1'b0;
    set_wr(0, 0, 0, 0, 12'h000, 1'b0);
    rom_data = '1;
    repeat (2) @(negedge clk);
    check("reset_rgb", 64'(rgb_out), 0);
    check("reset_hsync", 64'(hsync_out), 1);
    check("reset_vsync", 64'(vsync_out), 1);
    check("reset_collide", 64'(collide), 0);
    check("reset_rom_addr", 64'(rom_addr), 0);
    reset = 1'b0;

    // Single sprite, frame 2: address, colour, edges, active gating, transparency
    wr(0, 100, 200, 2, 12'hABC, 1'b1);
    pix(0, 0, 1'b0, 1'b1);
    pix(100, 200, 1'b1, 1'b0);
    check("addr0_origin", 64'(addr(0)), 7200);
    pix(101, 200, 1'b1, 1'b0);
    check("rgb_hit", 64'(rgb_out), 64'h0ABC);
    check("addr0_next", 64'(addr(0)), 7201);
    pix(99, 200, 1'b1, 1'b0);
    check("addr0_left_out", 64'(addr(0)), 0);
    pix(159, 259, 1'b1, 1'b0);
    check("rgb_x99_bg", 64'(rgb_out), 64'(BG));
    check("addr0_corner", 64'(addr(0)), 10799);
    pix(160, 259, 1'b1, 1'b0);
    check("rgb_corner", 64'(rgb_out), 64'h0ABC);
    check("addr0_right_out", 64'(addr(0)), 0);
    pix(100, 200, 1'b0, 1'b0);
    check("rgb_x160_bg", 64'(rgb_out), 64'(BG));
    pix(0, 0, 1'b1, 1'b0);
    check("rgb_inactive", 64'(rgb_out), 0);
    rom_data = 4'b1110;
    pix(100, 200, 1'b1, 1'b0);
    pix(0, 0, 1'b1, 1'b0);
    check("rgb_transparent", 64'(rgb_out), 64'(BG));
    rom_data = '1;
    wr(0, 100, 200, 7, 12'hABC, 1'b1);
    pix(0, 0, 1'b0, 1'b1);
    pix(159, 259, 1'b1, 1'b0);
    check("addr0_max_clamped", 64'(addr(0)), 21599);

    // Overlap: priority and collision reporting
    wr(0, 100, 200, 0, 12'hF00, 1'b1);
    wr(1, 130, 200, 0, 12'h0F0, 1'b1);
    pix(0, 0, 1'b0, 1'b1);
    check("collide_none", 64'(collide), 0);
    pix(140, 210, 1'b1, 1'b0);
    pix(0, 0, 1'b1, 1'b0);
    check("rgb_priority", 64'(rgb_out), 64'h0F00);
    pix(0, 0, 1'b0, 1'b1);
    check("collide_pair", 64'(collide), 64'h0012);
    check("collide_any_set", 64'(collide_any), 1);
    pix(0, 0, 1'b0, 1'b0);
    pix(0, 0, 1'b0, 1'b1);
    check("collide_cleared", 64'(collide), 0);
    check("collide_any_clr", 64'(collide_any), 0);
    pix(140, 210, 1'b1, 1'b0);
    pix(0, 0, 1'b0, 1'b1);
    check("collide_boundary_px", 64'(collide), 64'h0012);
    pix(165, 210, 1'b1, 1'b0);
    pix(0, 0, 1'b1, 1'b0);
    check("rgb_ch1_only", 64'(rgb_out), 64'h00F0);

    // Asynchronous reset mid-line, then two-strobe recovery
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_rgb", 64'(rgb_out), 0);
    check("midreset_collide", 64'(collide), 0);
    check("midreset_any", 64'(collide_any), 0);
    @(negedge clk);
    reset = 1'b0;
    bg_color = 12'h456;
    hsync_in = 1'b0;
    pix(5, 5, 1'b1, 1'b0);
    check("post_reset_rgb1", 64'(rgb_out), 0);
    check("post_reset_hs1", 64'(hsync_out), 1);
    hsync_in = 1'b1;
    bg_color = BG;
    pix(6, 5, 1'b1, 1'b0);
    check("post_reset_rgb2", 64'(rgb_out), 64'h0456);
    check("post_reset_hs2", 64'(hsync_out), 0);

    // Write landing on the frame_start strobe takes effect one frame later
    wr(2, 200, 100, 0, 12'h00F, 1'b1);
    pix(0, 0, 1'b0, 1'b1);
    set_wr(2, 300, 100, 0, 12'h00F, 1'b1);
    pix(0, 0, 1'b0, 1'b1, 1'b1);
    pix(210, 105, 1'b1, 1'b0);
    check("addr2_old_x", 64'(addr(2)), 310);
    pix(310, 105, 1'b1, 1'b0);
    check("rgb_old_x", 64'(rgb_out), 64'h000F);
    check("addr2_new_pos_early", 64'(addr(2)), 0);
    pix(0, 0, 1'b0, 1'b1);
    check("rgb_new_pos_early", 64'(rgb_out), 64'(BG));
    pix(310, 105, 1'b1, 1'b0);
    check("addr2_new_x", 64'(addr(2)), 310);
    pix(210, 105, 1'b1, 1'b0);
    check("rgb_new_x", 64'(rgb_out), 64'h000F);
    check("addr2_old_pos_late", 64'(addr(2)), 0);

    // Negative x: partly off the left edge, no wrap at the right edge
    wr(3, -20, 50, 0, 12'h0F0, 1'b1);
    pix(0, 0, 1'b0, 1'b1);
    pix(0, 60, 1'b1, 1'b0);
    check("addr3_x0", 64'(addr(3)), 620);
    pix(39, 60, 1'b1, 1'b0);
    check("addr3_x39", 64'(addr(3)), 659);
    check("rgb_neg_x", 64'(rgb_out), 64'h00F0);
    pix(40, 60, 1'b1, 1'b0);
    check("addr3_x40", 64'(addr(3)), 0);
    pix(620, 60, 1'b1, 1'b0);
    check("addr3_x620", 64'(addr(3)), 0);
    pix(639, 60, 1'b1, 1'b0);
    check("addr3_x639", 64'(addr(3)), 0);
    pix(0, 0, 1'b1, 1'b0);
    check("rgb_no_wrap", 64'(rgb_out), 64'(BG));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
